// File: rtl/mem_responder_if.sv
// Channel bus between request masters and the memory responder.
// Every field is a packed vector with one slice per channel.
interface mem_responder_if #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4
);

  logic [NUM_CHANNELS-1:0]                mem_read_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address;
  logic [NUM_CHANNELS-1:0]                mem_read_ready;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data;

  logic [NUM_CHANNELS-1:0]                mem_write_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data;
  logic [NUM_CHANNELS-1:0]                mem_write_ready;

  // Requesters drive valid/address/data and observe the responses
  modport master (
    output mem_read_valid, mem_read_address,
    input  mem_read_ready, mem_read_data,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_write_ready
  );

  // The responder observes requests and drives the responses
  modport slave (
    input  mem_read_valid, mem_read_address,
    output mem_read_ready, mem_read_data,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_write_ready
  );

endinterface

// File: rtl/mem_responder.sv
// Multi-channel memory responder with fixed-latency reads and writes.
// Every read channel and every write channel runs its own IDLE/BUSY/RESP FSM.
// All channels share one storage array, which also has a backdoor preload port.
// Reset clears the channel state but leaves the storage contents alone.
module mem_responder #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int LATENCY      = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_responder_if.slave       bus,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_address,
  input  logic [DATA_BITS-1:0] load_data
);

  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } chState_t;

  logic [DATA_BITS-1:0] mem_q [DEPTH];

  chState_t                               rdState_q [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0][3:0]           rdCnt_q;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] rdAddr_q;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] rdData_q;
  logic [NUM_CHANNELS-1:0]                rdReady_q;

  chState_t                               wrState_q [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0][3:0]           wrCnt_q;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] wrAddr_q;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] wrData_q;
  logic [NUM_CHANNELS-1:0]                wrReady_q;

  logic [NUM_CHANNELS-1:0]                wrCommit;

  // A write commits when its countdown expires; reset on that edge drops it
  always_comb begin
    wrCommit = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      wrCommit[c] = reset && (wrState_q[c] == BUSY) && (wrCnt_q[c] == 4'd0);
    end
  end

  // Storage update: the preload goes first, then channels in ascending order,
  // so the highest committing channel overrides both lower channels and the preload
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_q[load_address] <= load_data;
    end
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (wrCommit[c]) begin
        mem_q[wrAddr_q[c]] <= wrData_q[c];
      end
    end
  end

  // Read channel FSMs; the commit samples the array before this edge's writes land
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        rdState_q[c] <= IDLE;
        rdCnt_q[c]   <= 4'd0;
        rdAddr_q[c]  <= '0;
        rdData_q[c]  <= '0;
        rdReady_q[c] <= 1'b0;
      end
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        case (rdState_q[c])
          IDLE: begin
            if (bus.mem_read_valid[c]) begin
              rdAddr_q[c]  <= bus.mem_read_address[c];
              rdCnt_q[c]   <= CNT_INIT;
              rdState_q[c] <= BUSY;
            end
          end
          BUSY: begin
            if (rdCnt_q[c] == 4'd0) begin
              rdData_q[c]  <= mem_q[rdAddr_q[c]];
              rdReady_q[c] <= 1'b1;
              rdState_q[c] <= RESP;
            end else begin
              rdCnt_q[c] <= rdCnt_q[c] - 4'd1;
            end
          end
          RESP: begin
            if (!bus.mem_read_valid[c]) begin
              rdReady_q[c] <= 1'b0;
              rdState_q[c] <= IDLE;
            end
          end
          default: begin
            rdReady_q[c] <= 1'b0;
            rdState_q[c] <= IDLE;
          end
        endcase
      end
    end
  end

  // Write channel FSMs; the array itself is updated through wrCommit
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        wrState_q[c] <= IDLE;
        wrCnt_q[c]   <= 4'd0;
        wrAddr_q[c]  <= '0;
        wrData_q[c]  <= '0;
        wrReady_q[c] <= 1'b0;
      end
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        case (wrState_q[c])
          IDLE: begin
            if (bus.mem_write_valid[c]) begin
              wrAddr_q[c]  <= bus.mem_write_address[c];
              wrData_q[c]  <= bus.mem_write_data[c];
              wrCnt_q[c]   <= CNT_INIT;
              wrState_q[c] <= BUSY;
            end
          end
          BUSY: begin
            if (wrCnt_q[c] == 4'd0) begin
              wrReady_q[c] <= 1'b1;
              wrState_q[c] <= RESP;
            end else begin
              wrCnt_q[c] <= wrCnt_q[c] - 4'd1;
            end
          end
          RESP: begin
            if (!bus.mem_write_valid[c]) begin
              wrReady_q[c] <= 1'b0;
              wrState_q[c] <= IDLE;
            end
          end
          default: begin
            wrReady_q[c] <= 1'b0;
            wrState_q[c] <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.mem_read_ready  = rdReady_q;
  assign bus.mem_read_data   = rdData_q;
  assign bus.mem_write_ready = wrReady_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder.
// Expected read data is pushed when a request is raised and popped when ready appears.
// Expected values come from a reference memory model that the bench keeps itself.
module tb_mem_responder;

  localparam int AB  = 8;
  localparam int DB  = 8;
  localparam int NCH = 4;
  localparam int LAT = 2;

  typedef struct {
    int             ch;
    logic [DB-1:0]  data;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          load_en;
  logic [AB-1:0] load_address;
  logic [DB-1:0] load_data;

  exp_t          expQ[$];
  logic [DB-1:0] model [1 << AB];
  int            total;
  int            bad;

  mem_responder_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NCH)) bus ();

  mem_responder #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NCH), .LATENCY(LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .load_en      (load_en),
    .load_address (load_address),
    .load_data    (load_data)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Backdoor preload, mirrored in the reference model
  task automatic preload(input logic [AB-1:0] a, input logic [DB-1:0] d);
    load_en      = 1'b1;
    load_address = a;
    load_data    = d;
    tick();
    load_en = 1'b0;
    model[a] = d;
  endtask

  // Raise a read request and queue the data it must return
  task automatic issue_read(input int ch, input logic [AB-1:0] a);
    bus.mem_read_address[ch] = a;
    bus.mem_read_valid[ch]   = 1'b1;
    expQ.push_back('{ch, model[a]});
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    total++;
    if (bus.mem_read_ready !== 4'h0) begin
      bad++;
      $display("[TB] FAIL reset_read_ready: got %h expected 0", bus.mem_read_ready);
    end
    total++;
    if (bus.mem_write_ready !== 4'h0) begin
      bad++;
      $display("[TB] FAIL reset_write_ready: got %h expected 0", bus.mem_write_ready);
    end
    total++;
    if (bus.mem_read_data !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_read_data: got %h expected 0", bus.mem_read_data);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_preload_read();
    exp_t e;
    int   n;
    preload(8'h10, 8'hAB);
    issue_read(0, 8'h10);
    tick();
    bus.mem_read_address[0] = 8'h00;
    n = 0;
    while (!bus.mem_read_ready[0] && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (n !== LAT) begin
      bad++;
      $display("[TB] FAIL preload_read_latency: got %0d expected %0d", n, LAT);
    end
    e = expQ.pop_front();
    total++;
    if (bus.mem_read_data[e.ch] !== e.data) begin
      bad++;
      $display("[TB] FAIL preload_read_data: got %h expected %h", bus.mem_read_data[e.ch], e.data);
    end
    tick();
    tick();
    total++;
    if (bus.mem_read_ready[0] !== 1'b1 || bus.mem_read_data[0] !== e.data) begin
      bad++;
      $display("[TB] FAIL resp_hold: got ready=%b data=%h expected ready=1 data=%h",
               bus.mem_read_ready[0], bus.mem_read_data[0], e.data);
    end
    bus.mem_read_valid[0] = 1'b0;
    tick();
    total++;
    if (bus.mem_read_ready[0] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL resp_exit_ready: got %b expected 0", bus.mem_read_ready[0]);
    end
    total++;
    if (bus.mem_read_data[0] !== e.data) begin
      bad++;
      $display("[TB] FAIL idle_data_hold: got %h expected %h", bus.mem_read_data[0], e.data);
    end
    tick();
  endtask

  task automatic test_write_then_read();
    exp_t e;
    int   n;
    bus.mem_write_address[1] = 8'h20;
    bus.mem_write_data[1]    = 8'h5A;
    bus.mem_write_valid[1]   = 1'b1;
    model[8'h20] = 8'h5A;
    tick();
    // valid drops mid-flight and the bus changes: the captured request must still complete
    bus.mem_write_valid[1]   = 1'b0;
    bus.mem_write_address[1] = 8'h99;
    bus.mem_write_data[1]    = 8'hFF;
    n = 0;
    while (!bus.mem_write_ready[1] && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (n !== LAT) begin
      bad++;
      $display("[TB] FAIL write_latency: got %0d expected %0d", n, LAT);
    end
    tick();
    total++;
    if (bus.mem_write_ready[1] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL write_resp_exit: got %b expected 0", bus.mem_write_ready[1]);
    end
    issue_read(2, 8'h20);
    tick();
    n = 0;
    while (!bus.mem_read_ready[2] && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (n !== LAT) begin
      bad++;
      $display("[TB] FAIL read_after_write_latency: got %0d expected %0d", n, LAT);
    end
    e = expQ.pop_front();
    total++;
    if (bus.mem_read_data[e.ch] !== e.data) begin
      bad++;
      $display("[TB] FAIL read_after_write_data: got %h expected %h", bus.mem_read_data[e.ch], e.data);
    end
    bus.mem_read_valid[2] = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_load_vs_write();
    exp_t e;
    int   n;
    bus.mem_write_address[0] = 8'h50;
    bus.mem_write_data[0]    = 8'h77;
    bus.mem_write_valid[0]   = 1'b1;
    model[8'h50] = 8'h77;
    tick();
    tick();
    // Preload the same address on the commit edge; the channel write must win
    load_en      = 1'b1;
    load_address = 8'h50;
    load_data    = 8'h33;
    tick();
    load_en = 1'b0;
    total++;
    if (bus.mem_write_ready[0] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL load_vs_write_ready: got %b expected 1", bus.mem_write_ready[0]);
    end
    bus.mem_write_valid[0] = 1'b0;
    tick();
    issue_read(0, 8'h50);
    tick();
    n = 0;
    while (!bus.mem_read_ready[0] && n < 20) begin
      tick();
      n++;
    end
    e = expQ.pop_front();
    total++;
    if (n !== LAT || bus.mem_read_data[e.ch] !== e.data) begin
      bad++;
      $display("[TB] FAIL load_vs_write_data: got %h after %0d cycles expected %h after %0d",
               bus.mem_read_data[e.ch], n, e.data, LAT);
    end
    bus.mem_read_valid[0] = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_write_collision();
    exp_t e;
    int   n;
    bus.mem_write_address[0] = 8'h30;
    bus.mem_write_data[0]    = 8'h11;
    bus.mem_write_address[3] = 8'h30;
    bus.mem_write_data[3]    = 8'h22;
    bus.mem_write_valid      = 4'b1001;
    model[8'h30] = 8'h22;
    tick();
    n = 0;
    while (!bus.mem_write_ready[0] && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (bus.mem_write_ready !== 4'b1001 || n !== LAT) begin
      bad++;
      $display("[TB] FAIL collision_ready: got %b after %0d cycles expected 1001 after %0d",
               bus.mem_write_ready, n, LAT);
    end
    bus.mem_write_valid = 4'b0000;
    tick();
    issue_read(1, 8'h30);
    tick();
    n = 0;
    while (!bus.mem_read_ready[1] && n < 20) begin
      tick();
      n++;
    end
    e = expQ.pop_front();
    total++;
    if (bus.mem_read_data[e.ch] !== e.data) begin
      bad++;
      $display("[TB] FAIL collision_data: got %h expected %h", bus.mem_read_data[e.ch], e.data);
    end
    bus.mem_read_valid[1] = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_read_write_same_edge();
    exp_t e;
    int   n;
    preload(8'h40, 8'h01);
    issue_read(1, 8'h40);
    bus.mem_write_address[2] = 8'h40;
    bus.mem_write_data[2]    = 8'h02;
    bus.mem_write_valid[2]   = 1'b1;
    model[8'h40] = 8'h02;
    tick();
    n = 0;
    while (!bus.mem_read_ready[1] && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (bus.mem_write_ready[2] !== 1'b1 || n !== LAT) begin
      bad++;
      $display("[TB] FAIL same_edge_ready: got wr=%b after %0d cycles expected wr=1 after %0d",
               bus.mem_write_ready[2], n, LAT);
    end
    e = expQ.pop_front();
    total++;
    if (bus.mem_read_data[e.ch] !== e.data) begin
      bad++;
      $display("[TB] FAIL same_edge_old_data: got %h expected %h", bus.mem_read_data[e.ch], e.data);
    end
    bus.mem_read_valid[1]  = 1'b0;
    bus.mem_write_valid[2] = 1'b0;
    tick();
    issue_read(3, 8'h40);
    tick();
    n = 0;
    while (!bus.mem_read_ready[3] && n < 20) begin
      tick();
      n++;
    end
    e = expQ.pop_front();
    total++;
    if (bus.mem_read_data[e.ch] !== e.data) begin
      bad++;
      $display("[TB] FAIL same_edge_new_data: got %h expected %h", bus.mem_read_data[e.ch], e.data);
    end
    bus.mem_read_valid[3] = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_all_reads();
    exp_t          e;
    int            n;
    logic [DB-1:0] v;
    logic [AB-1:0] a;
    for (int i = 0; i < NCH; i++) begin
      a = 8'h60 + 8'(i);
      v = 8'($urandom_range(0, 255));
      preload(a, v);
    end
    for (int i = 0; i < NCH; i++) begin
      a = 8'h60 + 8'(i);
      issue_read(i, a);
    end
    tick();
    n = 0;
    while (bus.mem_read_ready == 4'h0 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (bus.mem_read_ready !== 4'hF || n !== LAT) begin
      bad++;
      $display("[TB] FAIL all_reads_ready: got %b after %0d cycles expected 1111 after %0d",
               bus.mem_read_ready, n, LAT);
    end
    for (int i = 0; i < NCH; i++) begin
      e = expQ.pop_front();
      total++;
      if (bus.mem_read_data[e.ch] !== e.data) begin
        bad++;
        $display("[TB] FAIL all_reads_data ch%0d: got %h expected %h",
                 e.ch, bus.mem_read_data[e.ch], e.data);
      end
    end
    bus.mem_read_valid = 4'h0;
    tick();
    tick();
  endtask

  task automatic test_reset_midflight();
    exp_t e;
    int   n;
    preload(8'h70, 8'hC3);
    issue_read(0, 8'h10);
    tick();
    tick();
    tick();
    e = expQ.pop_front();
    total++;
    if (bus.mem_read_ready[0] !== 1'b1 || bus.mem_read_data[e.ch] !== e.data) begin
      bad++;
      $display("[TB] FAIL midflight_setup: got ready=%b data=%h expected ready=1 data=%h",
               bus.mem_read_ready[0], bus.mem_read_data[e.ch], e.data);
    end
    bus.mem_write_address[1] = 8'h70;
    bus.mem_write_data[1]    = 8'h99;
    bus.mem_write_valid[1]   = 1'b1;
    tick();
    tick();
    // Reset lands on the edge where the write would otherwise commit
    reset              = 1'b0;
    bus.mem_read_valid  = 4'h0;
    bus.mem_write_valid = 4'h0;
    tick();
    total++;
    if (bus.mem_read_ready !== 4'h0 || bus.mem_write_ready !== 4'h0) begin
      bad++;
      $display("[TB] FAIL midflight_reset_ready: got rd=%b wr=%b expected 0000/0000",
               bus.mem_read_ready, bus.mem_write_ready);
    end
    total++;
    if (bus.mem_read_data !== 32'h0) begin
      bad++;
      $display("[TB] FAIL midflight_reset_data: got %h expected 0", bus.mem_read_data);
    end
    // Request raised together with reset release is taken on the first edge
    reset = 1'b1;
    issue_read(3, 8'h70);
    tick();
    n = 0;
    while (!bus.mem_read_ready[3] && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (n !== LAT) begin
      bad++;
      $display("[TB] FAIL post_reset_latency: got %0d expected %0d", n, LAT);
    end
    e = expQ.pop_front();
    total++;
    if (bus.mem_read_data[e.ch] !== e.data) begin
      bad++;
      $display("[TB] FAIL dropped_write_target: got %h expected %h", bus.mem_read_data[e.ch], e.data);
    end
    bus.mem_read_valid[3] = 1'b0;
    tick();
    issue_read(0, 8'h10);
    tick();
    n = 0;
    while (!bus.mem_read_ready[0] && n < 20) begin
      tick();
      n++;
    end
    e = expQ.pop_front();
    total++;
    if (bus.mem_read_data[e.ch] !== e.data) begin
      bad++;
      $display("[TB] FAIL preload_survives_reset: got %h expected %h", bus.mem_read_data[e.ch], e.data);
    end
    bus.mem_read_valid[0] = 1'b0;
    tick();
  endtask

  // Main sequence
  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    load_en = 1'b0;
    load_address = '0;
    load_data = '0;
    bus.mem_read_valid    = '0;
    bus.mem_read_address  = '0;
    bus.mem_write_valid   = '0;
    bus.mem_write_address = '0;
    bus.mem_write_data    = '0;
    #1;
    test_reset();
    test_preload_read();
    test_write_then_read();
    test_load_vs_write();
    test_write_collision();
    test_read_write_same_edge();
    test_all_reads();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
